// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM state encoding for the instruction-memory boot loader.
// Optional checksum trailer is enabled by defining IMEM_LOADER_CSUM_EN.
package imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         DEPTH0_DEF    = 336;
  localparam int         DEPTH1_DEF    = 77;

  typedef enum logic [3:0] {
    IDLE,
    BANK,
    CNT_LO,
    CNT_HI,
    DATA,
    WRITE,
    DRAIN,
    CSUM,
    FIN,
    ERRS
  } state_e;

endpackage

// File: rtl/imem_word_packer.sv
// Collects four bytes into a little-endian 32-bit word; word_full flags the 4th push.
// The byte counter wraps, so the next word starts without an explicit clear.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic [7:0]  byte_in,
  output logic        word_full,
  output logic [31:0] word
);

  logic [1:0]  count_q, count_d;
  logic [31:0] shreg_q, shreg_d;

  always_comb begin
    count_d = count_q;
    shreg_d = shreg_q;
    if (clr) begin
      count_d = 2'd0;
      shreg_d = 32'd0;
    end else if (push) begin
      count_d = count_q + 2'd1;
      // Earlier bytes slide down so the first byte lands in bits 7:0.
      shreg_d = {byte_in, shreg_q[31:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      shreg_q <= 32'd0;
    end else begin
      count_q <= count_d;
      shreg_q <= shreg_d;
    end
  end

  assign word_full = push && (count_q == 2'd3);
  assign word      = shreg_q;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader writing 32-bit words into instruction bank 0 or 1.
// Define IMEM_LOADER_CSUM_EN to require a trailing XOR checksum byte per frame.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         DEPTH0    = DEPTH0_DEF,
  parameter int         DEPTH1    = DEPTH1_DEF,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        wr_en,
  output logic        wr_sel,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [15:0] DEPTH0_W = 16'(DEPTH0);
  localparam logic [15:0] DEPTH1_W = 16'(DEPTH1);
`ifdef IMEM_LOADER_CSUM_EN
  localparam state_e PAYLOAD_END = CSUM;
`else
  localparam state_e PAYLOAD_END = FIN;
`endif

  state_e      state_q, state_d;
  logic        bank_q, bank_d;
  logic [7:0]  cnt_lo_q, cnt_lo_d;
  logic [15:0] n_q, n_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [15:0] cnt_w;
  logic        hs, push, word_full;
  logic [31:0] word;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]  csum_q, csum_d;
  logic        drain_q, drain_d;
`endif

  assign in_ready = !(state_q inside {WRITE, FIN, ERRS});
  assign hs       = in_valid && in_ready;
  assign push     = hs && (state_q inside {DATA, DRAIN});
  assign cnt_w    = {in_data, cnt_lo_q};

  imem_word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q == IDLE),
    .push      (push),
    .byte_in   (in_data),
    .word_full (word_full),
    .word      (word)
  );

  always_comb begin
    state_d    = state_q;
    bank_d     = bank_q;
    cnt_lo_d   = cnt_lo_q;
    n_d        = n_q;
    word_idx_d = word_idx_q;
    wr_en      = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d     = push ? (csum_q ^ in_data) : csum_q;
    drain_d    = drain_q;
`endif
    unique case (state_q)
      IDLE: begin
        word_idx_d = 16'd0;
`ifdef IMEM_LOADER_CSUM_EN
        csum_d     = 8'd0;
        drain_d    = 1'b0;
`endif
        if (hs && in_data == SYNC_BYTE) state_d = BANK;
      end
      BANK: if (hs) begin
        bank_d  = in_data[0];
        state_d = CNT_LO;
      end
      CNT_LO: if (hs) begin
        cnt_lo_d = in_data;
        state_d  = CNT_HI;
      end
      CNT_HI: if (hs) begin
        n_d = cnt_w;
        if (cnt_w == 16'd0)                             state_d = PAYLOAD_END;
        else if (cnt_w > (bank_q ? DEPTH1_W : DEPTH0_W)) state_d = DRAIN;
        else                                            state_d = DATA;
      end
      DATA: if (word_full) state_d = WRITE;
      WRITE: begin
        wr_en      = 1'b1;
        word_idx_d = word_idx_q + 16'd1;
        state_d    = (word_idx_q + 16'd1 < n_q) ? DATA : PAYLOAD_END;
      end
      // Oversized frames reuse word_idx to count discarded words.
      DRAIN: if (word_full) begin
        word_idx_d = word_idx_q + 16'd1;
        if (word_idx_q + 16'd1 == n_q) begin
`ifdef IMEM_LOADER_CSUM_EN
          drain_d = 1'b1;
          state_d = CSUM;
`else
          state_d = ERRS;
`endif
        end
      end
      CSUM: begin
`ifdef IMEM_LOADER_CSUM_EN
        if (hs) state_d = (in_data == csum_q && !drain_q) ? FIN : ERRS;
`else
        state_d = ERRS;
`endif
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERRS: begin
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bank_q     <= 1'b0;
      cnt_lo_q   <= 8'd0;
      n_q        <= 16'd0;
      word_idx_q <= 16'd0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q     <= 8'd0;
      drain_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      cnt_lo_q   <= cnt_lo_d;
      n_q        <= n_d;
      word_idx_q <= word_idx_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q     <= csum_d;
      drain_q    <= drain_d;
`endif
    end
  end

  assign busy    = (state_q != IDLE);
  assign wr_sel  = wr_en & bank_q;
  assign wr_addr = wr_en ? {14'd0, word_idx_q, 2'b00} : 32'd0;
  assign wr_data = wr_en ? word : 32'd0;

endmodule
